// File: rtl/clock_pkg.sv
// Shared definitions for the clock/stopwatch front panel: display modes,
// editable time fields and the per-field increment rule.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_SET_ALARM = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    localparam logic [7:0] MAX_HOUR   = 8'd23;
    localparam logic [7:0] MAX_MINSEC = 8'd59;

    function automatic logic [2:0] field_onehot(input field_e f);
        logic [2:0] oh;
        case (f)
            FIELD_SEC:  oh = 3'b001;
            FIELD_MIN:  oh = 3'b010;
            FIELD_HOUR: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic field_e field_next(input field_e f);
        field_e nxt;
        case (f)
            FIELD_HOUR: nxt = FIELD_MIN;
            FIELD_MIN:  nxt = FIELD_SEC;
            default:    nxt = FIELD_HOUR;
        endcase
        return nxt;
    endfunction

    // Anything at or beyond the field maximum (including garbage) wraps to 0.
    function automatic logic [7:0] field_inc(input logic [23:0] src, input field_e f);
        logic [7:0] v;
        logic [7:0] mx;
        case (f)
            FIELD_SEC: begin
                v  = src[7:0];
                mx = MAX_MINSEC;
            end
            FIELD_MIN: begin
                v  = src[15:8];
                mx = MAX_MINSEC;
            end
            default: begin
                v  = src[23:16];
                mx = MAX_HOUR;
            end
        endcase
        return (v >= mx) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// Rising-edge press detector with an optional hold/auto-repeat down-counter.
// Input is registered once, so press and repeat refer to the sampled level.
module button_repeat #(
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic arm_en,
    input  logic clear,
    output logic press,
    output logic rpt
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    logic             sample_q, sample_d;
    logic             prev_q, prev_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sample_d = btn;
        prev_d   = sample_q;
        press    = sample_q & ~prev_q;
        rpt      = armed_q & sample_q & (cnt_q == '0);
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        if (!sample_q || clear) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (press && arm_en) begin
            armed_d = 1'b1;
            cnt_d   = DELAY_LOAD;
        end else if (armed_q) begin
            cnt_d = rpt ? PERIOD_LOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sample_q <= sample_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_controller.sv
// Front-panel sequencer: turns three debounced buttons into the mode bus,
// stopwatch pulses and per-field load strobes for the time and alarm counters.
//   state          | meaning
//   MODE_CLOCK     | normal display, sel/inc ignored
//   MODE_SET_TIME  | edit time field, inc loads time counters
//   MODE_STOPWATCH | sel = start/stop, inc = stopwatch reset
//   MODE_SET_ALARM | edit alarm field, inc loads alarm registers
module mode_controller
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned TIMEOUT       = 500000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic [23:0] time_data,
    input  logic [23:0] alarm_data,
    output logic [1:0]  rezhim,
    output logic        button_start_stop,
    output logic        button_reset,
    output logic [2:0]  setup_imp,
    output logic [2:0]  alarm_setup_imp,
    output logic [7:0]  setup_data,
    output logic [2:0]  edit_field
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic press_mode, press_sel, press_inc, rpt_inc;
    logic unused_rpt_mode, unused_rpt_sel;
    logic edit_mode, timeout_hit, inc_clear;
    logic [7:0] load_val;

    mode_e              mode_q, mode_d;
    field_e             field_q, field_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [23:0]        time_q, time_d;
    logic [23:0]        alarm_q, alarm_d;
    logic               start_stop_q, start_stop_d;
    logic               reset_pulse_q, reset_pulse_d;
    logic [2:0]         setup_imp_q, setup_imp_d;
    logic [2:0]         alarm_imp_q, alarm_imp_d;
    logic [7:0]         setup_data_q, setup_data_d;
    logic [2:0]         edit_field_q, edit_field_d;

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
        .clock(clock), .reset(reset), .btn(btn_mode), .arm_en(1'b0), .clear(1'b0),
        .press(press_mode), .rpt(unused_rpt_mode)
    );

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_sel (
        .clock(clock), .reset(reset), .btn(btn_sel), .arm_en(1'b0), .clear(1'b0),
        .press(press_sel), .rpt(unused_rpt_sel)
    );

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
        .clock(clock), .reset(reset), .btn(btn_inc), .arm_en(edit_mode), .clear(inc_clear),
        .press(press_inc), .rpt(rpt_inc)
    );

    assign edit_mode   = (mode_q == MODE_SET_TIME) || (mode_q == MODE_SET_ALARM);
    // Any press or repeat in the same cycle beats the timeout.
    assign timeout_hit = edit_mode && (idle_q == IDLE_LAST)
                         && !press_mode && !press_sel && !press_inc && !rpt_inc;
    assign inc_clear   = press_mode | press_sel | timeout_hit;

    always_comb begin
        mode_d        = mode_q;
        field_d       = field_q;
        idle_d        = idle_q;
        time_d        = time_data;
        alarm_d       = alarm_data;
        start_stop_d  = 1'b0;
        reset_pulse_d = 1'b0;
        setup_imp_d   = 3'b000;
        alarm_imp_d   = 3'b000;
        setup_data_d  = 8'd0;
        load_val      = field_inc((mode_q == MODE_SET_TIME) ? time_q : alarm_q, field_q);

        if (press_mode) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            field_d = FIELD_HOUR;
            idle_d  = '0;
        end else if (edit_mode) begin
            if (press_sel) begin
                field_d = field_next(field_q);
                idle_d  = '0;
            end else if (press_inc || rpt_inc) begin
                idle_d       = '0;
                setup_data_d = load_val;
                if (mode_q == MODE_SET_TIME) begin
                    setup_imp_d = field_onehot(field_q);
                end else begin
                    alarm_imp_d = field_onehot(field_q);
                end
            end else if (timeout_hit) begin
                mode_d = MODE_CLOCK;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
            if (mode_q == MODE_STOPWATCH) begin
                if (press_sel) begin
                    start_stop_d = 1'b1;
                end else if (press_inc) begin
                    reset_pulse_d = 1'b1;
                end
            end
        end

        edit_field_d = ((mode_d == MODE_SET_TIME) || (mode_d == MODE_SET_ALARM))
                       ? field_onehot(field_d) : 3'b000;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q        <= MODE_CLOCK;
            field_q       <= FIELD_HOUR;
            idle_q        <= '0;
            time_q        <= '0;
            alarm_q       <= '0;
            start_stop_q  <= 1'b0;
            reset_pulse_q <= 1'b0;
            setup_imp_q   <= 3'b000;
            alarm_imp_q   <= 3'b000;
            setup_data_q  <= 8'd0;
            edit_field_q  <= 3'b000;
        end else begin
            mode_q        <= mode_d;
            field_q       <= field_d;
            idle_q        <= idle_d;
            time_q        <= time_d;
            alarm_q       <= alarm_d;
            start_stop_q  <= start_stop_d;
            reset_pulse_q <= reset_pulse_d;
            setup_imp_q   <= setup_imp_d;
            alarm_imp_q   <= alarm_imp_d;
            setup_data_q  <= setup_data_d;
            edit_field_q  <= edit_field_d;
        end
    end

    assign rezhim            = mode_q;
    assign button_start_stop = start_stop_q;
    assign button_reset      = reset_pulse_q;
    assign setup_imp         = setup_imp_q;
    assign alarm_setup_imp   = alarm_imp_q;
    assign setup_data        = setup_data_q;
    assign edit_field        = edit_field_q;

endmodule

// File: tb/tb_mode_controller.sv
// Bench for mode_controller: directed vector table, hand-written timeout and
// reset sequences, then random buttons against an event-level reference model.
module tb_mode_controller;

    localparam int D  = 4;
    localparam int P  = 2;
    localparam int TO = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0, btn_sel = 1'b0, btn_inc = 1'b0;
    logic [23:0] time_data = '0, alarm_data = '0;
    logic [1:0]  rezhim;
    logic        button_start_stop, button_reset;
    logic [2:0]  setup_imp, alarm_setup_imp, edit_field;
    logic [7:0]  setup_data;

    mode_controller #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .time_data(time_data), .alarm_data(alarm_data),
        .rezhim(rezhim), .button_start_stop(button_start_stop), .button_reset(button_reset),
        .setup_imp(setup_imp), .alarm_setup_imp(alarm_setup_imp),
        .setup_data(setup_data), .edit_field(edit_field)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode number, field index (0 sec,1 min,2 hour), cycles held
    // since the inc press (-1 = not holding), idle cycles, and the one-cycle input samples.
    int          m_mode, m_field, m_held, m_idle;
    bit          m_ms, m_ss, m_is, m_mp, m_sp, m_ip;
    logic [23:0] m_td, m_ad;
    logic [20:0] m_exp;

    typedef struct {
        bit          bm, bs, bi;
        logic [23:0] td, ad;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [20:0] dut_out();
        return {rezhim, button_start_stop, button_reset, setup_imp, alarm_setup_imp, setup_data, edit_field};
    endfunction

    function automatic vec_t mk(input bit bm, bs, bi, input logic [23:0] td, ad,
                                input logic [1:0] rz, input bit ss, rst,
                                input logic [2:0] simp, aimp, input logic [7:0] data,
                                input logic [2:0] ef);
        vec_t r;
        r.bm = bm; r.bs = bs; r.bi = bi; r.td = td; r.ad = ad;
        r.exp = {rz, ss, rst, simp, aimp, data, ef};
        return r;
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual rz=%0d ss=%b rst=%b simp=%b aimp=%b data=%h ef=%b, required rz=%0d ss=%b rst=%b simp=%b aimp=%b data=%h ef=%b",
                     name, $time, act[20:19], act[18], act[17], act[16:14], act[13:11], act[10:3], act[2:0],
                     exp[20:19], exp[18], exp[17], exp[16:14], exp[13:11], exp[10:3], exp[2:0]);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 2; m_held = -1; m_idle = 0;
        m_ms = 0; m_ss = 0; m_is = 0; m_mp = 0; m_sp = 0; m_ip = 0;
        m_td = '0; m_ad = '0; m_exp = '0;
    endtask

    task automatic model_step(input bit bm, bs, bi, input logic [23:0] td, ad);
        bit pm, ps, pi, rep, edit, e_ss, e_rst;
        logic [23:0] src;
        int v, mx;
        logic [7:0] data;
        logic [2:0] simp, aimp, ef;
        pm = m_ms && !m_mp;
        ps = m_ss && !m_sp;
        pi = m_is && !m_ip;
        data = 0; simp = 0; aimp = 0; e_ss = 0; e_rst = 0; rep = 0;
        edit = (m_mode == 1) || (m_mode == 3);
        if (m_held >= 0) begin
            if (m_is) begin
                m_held++;
                rep = (m_held >= D) && (((m_held - D) % P) == 0);
            end else begin
                m_held = -1;
            end
        end
        if (pm) begin
            m_mode = (m_mode + 1) % 4; m_field = 2; m_idle = 0; m_held = -1;
        end else if (edit) begin
            if (ps) begin
                m_field = (m_field == 0) ? 2 : m_field - 1;
                m_held = -1; m_idle = 0;
            end else if (pi || rep) begin
                src  = (m_mode == 1) ? m_td : m_ad;
                v    = int'((src >> (8 * m_field)) & 24'hFF);
                mx   = (m_field == 2) ? 23 : 59;
                data = (v >= mx) ? 8'd0 : 8'(v + 1);
                if (m_mode == 1) simp = 3'(1 << m_field);
                else             aimp = 3'(1 << m_field);
                m_idle = 0;
                if (pi) m_held = 0;
            end else begin
                m_idle++;
                if (m_idle >= TO) begin
                    m_mode = 0; m_idle = 0; m_held = -1;
                end
            end
        end else begin
            m_idle = 0;
            if (m_mode == 2) begin
                if (ps)      e_ss  = 1;
                else if (pi) e_rst = 1;
            end
        end
        ef = ((m_mode == 1) || (m_mode == 3)) ? 3'(1 << m_field) : 3'b000;
        m_exp = {2'(m_mode), e_ss, e_rst, simp, aimp, data, ef};
        m_mp = m_ms; m_sp = m_ss; m_ip = m_is;
        m_ms = bm;   m_ss = bs;   m_is = bi;
        m_td = td;   m_ad = ad;
    endtask

    task automatic step(input bit bm, bs, bi, input logic [23:0] td, ad);
        btn_mode = bm; btn_sel = bs; btn_inc = bi; time_data = td; alarm_data = ad;
        @(posedge clock);
        model_step(bm, bs, bi, td, ad);
        #1;
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b0;
        #1;
        model_reset();
        check(name, dut_out(), 21'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [23:0] td, ad;
        bit bm, bs, bi;

        // Directed table: each row's expectation reflects presses sampled one row earlier.
        td = 24'h173B3B; ad = 24'h0C0A05;
        tbl.push_back(mk(1,0,0, td, ad, 0,0,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,1, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b100,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,1,0, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        tbl.push_back(mk(0,0,1, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b010,3'b000, 8'h00, 3'b010));
        tbl.push_back(mk(0,1,0, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b001));
        tbl.push_back(mk(0,0,1, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b001));
        tbl.push_back(mk(0,0,0, td, ad, 1,0,0, 3'b001,3'b000, 8'h00, 3'b001));
        tbl.push_back(mk(0,0,1, 24'h0A1405, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b001));
        tbl.push_back(mk(0,0,0, 24'h0A1405, ad, 1,0,0, 3'b001,3'b000, 8'h06, 3'b001));
        tbl.push_back(mk(0,1,0, 24'h200000, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b001));
        tbl.push_back(mk(0,0,0, 24'h200000, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,1, 24'h200000, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, 24'h200000, ad, 1,0,0, 3'b100,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,1, 24'h160000, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, 24'h160000, ad, 1,0,0, 3'b100,3'b000, 8'h17, 3'b100));
        tbl.push_back(mk(1,0,1, td, ad, 1,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, td, ad, 2,0,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,1,0, td, ad, 2,0,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,0,0, td, ad, 2,1,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,0,1, td, ad, 2,0,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,0,0, td, ad, 2,0,1, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(1,0,0, td, ad, 2,0,0, 3'b000,3'b000, 8'h00, 3'b000));
        tbl.push_back(mk(0,0,0, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,1,0, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b100));
        tbl.push_back(mk(0,0,0, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        // Hold inc for 11 samples on the alarm minute field (value 10).
        for (int k = 0; k < 11; k++) begin
            if (k == 1 || k == 5 || k == 7 || k == 9)
                tbl.push_back(mk(0,0,1, td, ad, 3,0,0, 3'b000,3'b010, 8'h0B, 3'b010));
            else
                tbl.push_back(mk(0,0,1, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        end
        tbl.push_back(mk(0,0,0, td, ad, 3,0,0, 3'b000,3'b010, 8'h0B, 3'b010));
        tbl.push_back(mk(0,0,0, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b010));
        tbl.push_back(mk(0,0,0, td, ad, 3,0,0, 3'b000,3'b000, 8'h00, 3'b010));

        #12;
        model_reset();
        check("reset_state", dut_out(), 21'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].bm, tbl[k].bs, tbl[k].bi, tbl[k].td, tbl[k].ad);
            check($sformatf("table[%0d]", k), dut_out(), tbl[k].exp);
        end

        // Edit-mode inactivity timeout.
        apply_reset("reset_before_timeout");
        step(1, 0, 0, 24'h0, 24'h0);
        step(0, 0, 0, 24'h0, 24'h0);
        check("timeout_enter", dut_out(), {2'd1, 1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 3'b100});
        for (int k = 1; k < TO; k++) begin
            step(0, 0, 0, 24'h0, 24'h0);
            check($sformatf("timeout_wait[%0d]", k), dut_out(), {2'd1, 1'b0, 1'b0, 3'b000, 3'b000, 8'h00, 3'b100});
        end
        step(0, 0, 0, 24'h0, 24'h0);
        check("timeout_fire", dut_out(), 21'd0);

        // Async reset in the middle of an auto-repeat hold.
        apply_reset("reset_before_hold");
        step(1, 0, 0, 24'h0, 24'h0);
        step(0, 0, 0, 24'h0, 24'h0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 24'h0, 24'h0);
        reset = 1'b0;
        #1;
        check("reset_mid_hold", dut_out(), 21'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 24'h0, 24'h0);
            check($sformatf("held_after_reset[%0d]", k), dut_out(), 21'd0);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 24'h0, 24'h0);
            check($sformatf("released_after_reset[%0d]", k), dut_out(), 21'd0);
        end

        // Random buttons and data against the reference model.
        apply_reset("reset_before_random");
        bm = 0; bs = 0; bi = 0;
        for (int c = 0; c < 4000; c++) begin
            if (bm) bm = ($urandom_range(0, 1) == 0); else bm = ($urandom_range(0, 39) == 0);
            if (bs) bs = ($urandom_range(0, 1) == 0); else bs = ($urandom_range(0, 9) == 0);
            if (bi) bi = ($urandom_range(0, 11) != 0); else bi = ($urandom_range(0, 7) == 0);
            td = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63))};
            ad = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63))};
            step(bm, bs, bi, td, ad);
            check("random", dut_out(), m_exp);
            if ($urandom_range(0, 499) == 0) apply_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
